// File: rtl/usb_rx_ctrl.sv
// USB full-speed receive control: frames packets from bit-timer, edge and EOP events.
// Optional PID complement check is enabled by defining USB_RX_PID_CHECK_EN.
module usb_rx_ctrl #(
  parameter int          MAX_BYTES = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'h80
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       shift_enable,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  output logic       rcving,
  output logic       w_enable,
  output logic       r_error,
  output logic       rx_done,
  output logic [3:0] rx_pid,
  output logic [6:0] byte_cnt
);

  typedef enum logic [3:0] {
    IDLE, RCV_SYNC, CHK_SYNC, RCV_PID, CHK_PID, RCV_DATA,
    STORE, EOP_WAIT, ERR_WAIT, ERR_EOP, ERR_IDLE
  } state_t;

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  state_t     state, state_n;
  logic       byte_rcv_q;
  logic [2:0] bit_cnt;
  logic       byte_pe, eop_se;
  logic       rcving_n, w_enable_n, r_error_n, rx_done_n;
  logic [3:0] rx_pid_n;
  logic [6:0] byte_cnt_n;

  // byte_received is a level; only its rising edge marks a new byte.
  assign byte_pe = byte_received & ~byte_rcv_q & rcving;
  assign eop_se  = eop & shift_enable;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      byte_rcv_q <= 1'b0;
      bit_cnt    <= '0;
      rcving     <= 1'b0;
      w_enable   <= 1'b0;
      r_error    <= 1'b0;
      rx_done    <= 1'b0;
      rx_pid     <= '0;
      byte_cnt   <= '0;
    end else begin
      state      <= state_n;
      byte_rcv_q <= byte_received;
      if (!rcving || byte_pe) bit_cnt <= '0;
      else if (shift_enable)  bit_cnt <= bit_cnt + 3'd1;
      rcving     <= rcving_n;
      w_enable   <= w_enable_n;
      r_error    <= r_error_n;
      rx_done    <= rx_done_n;
      rx_pid     <= rx_pid_n;
      byte_cnt   <= byte_cnt_n;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n    = state;
    w_enable_n = 1'b0;
    rx_done_n  = 1'b0;
    rx_pid_n   = rx_pid;
    byte_cnt_n = byte_cnt;

    unique case (state)
      IDLE: if (d_edge) begin
        state_n    = RCV_SYNC;
        byte_cnt_n = '0;
      end
      RCV_SYNC: begin
        if (eop_se)       state_n = ERR_EOP;
        else if (byte_pe) state_n = CHK_SYNC;
      end
      CHK_SYNC: state_n = (rcv_data == SYNC_BYTE) ? RCV_PID : ERR_WAIT;
      RCV_PID: begin
        if (eop_se)       state_n = ERR_EOP;
        else if (byte_pe) state_n = CHK_PID;
      end
      CHK_PID: begin
        rx_pid_n = rcv_data[3:0];
`ifdef USB_RX_PID_CHECK_EN
        state_n  = (rcv_data[7:4] == ~rcv_data[3:0]) ? RCV_DATA : ERR_WAIT;
`else
        state_n  = RCV_DATA;
`endif
      end
      RCV_DATA: begin
        // EOP at a sample point takes priority over a coincident byte edge.
        if (eop_se) begin
          state_n = (bit_cnt == 3'd0) ? EOP_WAIT : ERR_EOP;
        end else if (byte_pe) begin
          if (byte_cnt >= MAX_CNT) begin
            state_n = ERR_WAIT;
          end else begin
            state_n    = STORE;
            w_enable_n = 1'b1;
            byte_cnt_n = byte_cnt + 7'd1;
          end
        end
      end
      STORE:    state_n = RCV_DATA;
      EOP_WAIT: if (d_edge) begin
        state_n   = IDLE;
        rx_done_n = 1'b1;
      end
      ERR_WAIT: if (eop_se) state_n = ERR_EOP;
      ERR_EOP:  if (d_edge) state_n = ERR_IDLE;
      ERR_IDLE: if (d_edge) begin
        state_n    = RCV_SYNC;
        byte_cnt_n = '0;
      end
      default:  state_n = IDLE;
    endcase

    // Level outputs follow the state being entered so they are registered.
    rcving_n  = !(state_n inside {IDLE, ERR_IDLE});
    r_error_n = state_n inside {ERR_WAIT, ERR_EOP, ERR_IDLE};
  end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
Receive control unit for the USB full-speed receiver. It consumes the bit-timer outputs (shift_enable, byte_received), the edge and EOP detectors, and the shift-register byte. From these it frames a packet: it gates the bit timer via rcving, validates SYNC and PID, and issues one-cycle write strobes into the RX FIFO. It sits directly downstream of the bit timer and upstream of the RX FIFO.

Parameters:
- MAX_BYTES, 64, maximum payload bytes after the PID; exceeding it is an error.
- SYNC_BYTE, 8'h80, expected first byte as presented LSB-first by the shift register.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- d_edge  input  1  one-cycle pulse on any D+/D- transition.
- eop  input  1  level; single-ended-zero currently on the bus.
- shift_enable  input  1  one-cycle pulse at each bit sample point.
- byte_received  input  1  level; high from the 8th shift until the next shift.
- rcv_data  input  8  current shift-register contents.
- rcving  output  1  packet in progress; enables the bit timer.
- w_enable  output  1  one-cycle FIFO write strobe for rcv_data.
- r_error  output  1  sticky packet error.
- rx_done  output  1  one-cycle pulse on a clean end of packet.
- rx_pid  output  4  PID of the last packet (low nibble of the PID byte).
- byte_cnt  output  7  payload bytes written in the current packet.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters 0.
- All outputs are registered. Control decisions take effect one clock after their trigger.
- byte_received is a level. The block reacts only to its rising edge (byte_pe), using an internal registered copy. byte_pe with rcving=0 is ignored.
- bit_cnt (3 bits): increments on shift_enable and clears on byte_pe. bit_cnt==0 means the packet is on a byte boundary.
- States:
  - IDLE: rcving=0. d_edge → RCV_SYNC; clear r_error and byte_cnt.
  - RCV_SYNC: rcving=1. byte_pe → CHK_SYNC. eop & shift_enable → ERR_EOP.
  - CHK_SYNC: rcv_data==SYNC_BYTE → RCV_PID; otherwise → ERR_WAIT.
  - RCV_PID: byte_pe → CHK_PID. eop & shift_enable → ERR_EOP.
  - CHK_PID: latch rx_pid=rcv_data[3:0]. PID check per Optional Feature; pass → RCV_DATA, fail → ERR_WAIT.
  - RCV_DATA: on byte_pe →
    - if byte_cnt==MAX_BYTES → ERR_WAIT;
    - otherwise → STORE.
  - RCV_DATA on eop & shift_enable:
    - bit_cnt==0 → EOP_WAIT;
    - otherwise → ERR_EOP.
  - STORE: w_enable=1 for exactly this cycle; byte_cnt+1; → RCV_DATA.
  - EOP_WAIT: rcving=1. d_edge (bus returns to idle J) → IDLE with rx_done=1 for one cycle.
  - ERR_WAIT: r_error=1, rcving=1; no writes. eop & shift_enable → ERR_EOP.
  - ERR_EOP: r_error=1. d_edge → ERR_IDLE.
  - ERR_IDLE: rcving=0, r_error held. d_edge → RCV_SYNC; r_error cleared in the same transition.
- Simultaneous events:
  - eop & shift_enable in the same cycle as byte_pe: EOP wins.
  - d_edge in STORE is ignored.
- byte_cnt saturates at MAX_BYTES and is never written beyond it.
- Reset mid-packet returns to IDLE immediately (asynchronous): rcving drops, no w_enable or rx_done is issued.

Optional Feature:
- Macro: USB_RX_PID_CHECK_EN.
- Defined: CHK_PID requires rcv_data[7:4] == ~rcv_data[3:0], otherwise → ERR_WAIT. The PID byte is never written to the FIFO.
- Undefined: no complement check; CHK_PID always → RCV_DATA. rx_pid is still latched.

Test Plan:
- Reset while in RCV_DATA → rcving=0, w_enable=0, r_error=0, byte_cnt=0 on the next sampled clock.
- d_edge, SYNC 8'h80, PID 8'hE1, data 8'hA5, 8'h3C, byte-aligned EOP then d_edge → w_enable pulses exactly 2, byte_cnt=2, rx_pid=4'h1, rx_done=1 for one cycle, r_error=0.
- SYNC received as 8'h81 → ERR_WAIT, r_error=1, no w_enable. After EOP and d_edge → ERR_IDLE; the next d_edge clears r_error.
- EOP after 3 data bits (bit_cnt=3) → ERR_EOP, r_error=1, no rx_done.
- With USB_RX_PID_CHECK_EN, PID 8'hE2 → r_error=1. Without it → accepted, rx_pid=4'h2.
- MAX_BYTES=4, send 5 data bytes → exactly 4 writes, r_error=1 on the 5th byte_pe, byte_cnt=4.
